seq_detector: RTL and testbench

Parametrised, programmable serial sequence detector; the general successor to the fixed three-state Moore detectors in this codebase. It accepts one bit per qualified cycle and compares a sliding window against a runtime-loaded pattern with a per-bit don't-care mask. It supports overlapping and non-overlapping detection and emits a registered one-cycle match pulse. It sits between a serial front end (deserialiser or UART bit stream) and control logic that reacts to frame markers.

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/seq_detector_if.sv | 50 +++++
 rtl/seq_det_window.sv | 70 +++++++
 rtl/seq_detector.sv | 101 ++++++++++
 tb/tb_seq_detector.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and constants for the programmable serial sequence detector.
//   state_t          : detector FSM state encoding (IDLE, FILL, DETECT)
//   PAT_W_MIN/MAX    : legal range of the pattern/window width
//   fill_cnt_w()     : width needed for a counter that saturates at PAT_W
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } state_t;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    function automatic int fill_cnt_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_if.sv
// -----------------------------------------------------------------------------
// seq_detector_if
// Bit-stream, configuration and status signals of the sequence detector.
//   en, bit_vld, bit_in          : serial input and detector enable
//   load, pat_in, mask_in, overlap: configuration strobe and values
//   match, busy                  : detector status (registered)
//   match_cnt                    : saturating hit count, only when the
//                                  MATCH_CNT_EN macro is defined
// Modports: master (stimulus / front end side), slave (detector side).
// -----------------------------------------------------------------------------
interface seq_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             bit_vld;
    logic             bit_in;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] mask_in;
    logic             overlap;
    logic             match;
    logic             busy;
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, bit_vld, bit_in, load, pat_in, mask_in, overlap,
        input  match, busy, match_cnt
    );
    modport slave (
        input  en, bit_vld, bit_in, load, pat_in, mask_in, overlap,
        output match, busy, match_cnt
    );
`else
    modport master (
        output en, bit_vld, bit_in, load, pat_in, mask_in, overlap,
        input  match, busy
    );
    modport slave (
        input  en, bit_vld, bit_in, load, pat_in, mask_in, overlap,
        output match, busy
    );
`endif

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("seq_detector_if: CNT_W must be at least 1");
    end

endinterface

// File: rtl/seq_det_window.sv
// -----------------------------------------------------------------------------
// seq_det_window
// Sliding bit window, fill counter and masked pattern compare.
//   clk, rst   : clock, async active-high reset
//   i_clear    : clear window and fill counter (configuration load)
//   i_accept   : shift i_bit into the window this cycle
//   i_bit      : serial data bit, lands at the window LSB
//   i_overlap  : 1 keeps the fill count after a hit, 0 restarts filling
//   i_pat      : pattern, MSB is the oldest bit
//   i_mask     : 1 = compare bit, 0 = don't care
//   o_hit      : this cycle's accepted bit completes a match (combinational)
//   o_full     : window will hold PAT_W counted bits after this edge
// -----------------------------------------------------------------------------
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_accept,
    input  logic             i_bit,
    input  logic             i_overlap,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [PAT_W-1:0] i_mask,
    output logic             o_hit,
    output logic             o_full
);
    localparam int             FC_W     = fill_cnt_w(PAT_W);
    localparam logic [FC_W-1:0] FILL_MAX = FC_W'(PAT_W);

    logic [PAT_W-1:0] r_win;
    logic [PAT_W-1:0] w_win_next;
    logic [FC_W-1:0]  r_fill_cnt;
    logic [FC_W-1:0]  w_fill_acc;
    logic [FC_W-1:0]  w_fill_next;

    always_comb begin
        w_win_next  = r_win;
        w_fill_acc  = r_fill_cnt;
        w_fill_next = r_fill_cnt;
        o_hit       = 1'b0;
        if (i_clear) begin
            w_win_next  = '0;
            w_fill_next = '0;
        end else if (i_accept) begin
            w_win_next  = {r_win[PAT_W-2:0], i_bit};
            w_fill_acc  = (r_fill_cnt == FILL_MAX) ? FILL_MAX : r_fill_cnt + 1'b1;
            o_hit       = (w_fill_acc == FILL_MAX) &&
                          (((w_win_next ^ i_pat) & i_mask) == '0);
            // Non-overlapping: the window contents are left alone, but the
            // next hit needs PAT_W fresh bits, which overwrite them entirely.
            w_fill_next = (o_hit && !i_overlap) ? '0 : w_fill_acc;
        end
    end

    assign o_full = (w_fill_next == FILL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win      <= '0;
            r_fill_cnt <= '0;
        end else begin
            r_win      <= w_win_next;
            r_fill_cnt <= w_fill_next;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
// Programmable serial sequence detector with per-bit don't-care mask and
// overlapping / non-overlapping detection.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_detector_if.slave (bit stream, config, match/busy status)
// Optional feature: define MATCH_CNT_EN to add the saturating match_cnt
// output (width CNT_W) on the interface.
//
// state  | meaning
// IDLE   | en low; window and fill count frozen
// FILL   | en high; fewer than PAT_W bits collected
// DETECT | en high; window full, every accepted bit is compared
// -----------------------------------------------------------------------------
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    seq_detector_if.slave bus
);
    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX || CNT_W < 1) begin : g_param_check
        $error("seq_detector: PAT_W must be 2..32 and CNT_W at least 1");
    end

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_mask;
    logic             r_overlap;
    logic             r_match;
    logic             w_accept;
    logic             w_hit;
    logic             w_full;

    // load wins over a simultaneous bit, which is dropped.
    assign w_accept = bus.en & bus.bit_vld & ~bus.load;

    seq_det_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (bus.load),
        .i_accept  (w_accept),
        .i_bit     (bus.bit_in),
        .i_overlap (r_overlap),
        .i_pat     (r_pat),
        .i_mask    (r_mask),
        .o_hit     (w_hit),
        .o_full    (w_full)
    );

    // w_full already reflects a non-overlapping hit clearing the fill count,
    // so DETECT -> FILL after such a hit falls out of the same decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pat     <= '0;
            r_mask    <= '0;
            r_overlap <= 1'b0;
            r_match   <= 1'b0;
        end else if (bus.load) begin
            r_pat     <= bus.pat_in;
            r_mask    <= bus.mask_in;
            r_overlap <= bus.overlap;
            r_match   <= 1'b0;
            r_state   <= bus.en ? FILL : IDLE;
        end else begin
            r_match <= w_hit;
            if (!bus.en) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_full ? DETECT : FILL;
            end
        end
    end

    assign bus.match = r_match;
    assign bus.busy  = (r_state != IDLE);

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] r_match_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
        end else if (bus.load) begin
            r_match_cnt <= '0;
        end else if (w_hit && (r_match_cnt != '1)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign bus.match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_detector
// Directed bench for seq_detector with PAT_W=4, CNT_W=2. Inputs change on the
// falling edge; outputs are checked on the following falling edge, i.e. after
// the rising edge that consumed the inputs. match_cnt checks are compiled in
// only when MATCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_detector;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detector #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs,
                           input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic b);
        bus.en      = e;
        bus.bit_vld = v;
        bus.bit_in  = b;
        bus.load    = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [PAT_W-1:0] pat, input logic [PAT_W-1:0] mask,
                           input logic ovl, input logic e, input logic v, input logic b);
        bus.pat_in  = pat;
        bus.mask_in = mask;
        bus.overlap = ovl;
        bus.en      = e;
        bus.bit_vld = v;
        bus.bit_in  = b;
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    // Feed n accepted bits (MSB first) and check match after each one.
    task automatic feed(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, bits[n-1-i]);
            chk($sformatf("%s_bit%0d", tag, i + 1), bus.match, exp[n-1-i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.bit_vld = 1'b0;
        bus.bit_in  = 1'b0;
        bus.load    = 1'b0;
        bus.pat_in  = '0;
        bus.mask_in = '0;
        bus.overlap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_match", bus.match, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
`ifdef MATCH_CNT_EN
        chk_cnt("rst_cnt", bus.match_cnt, 2'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Overlapping 1011 over 1011011: hits on bits 4 and 7.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovl_load_match", bus.match, 1'b0);
        chk("ovl_load_busy", bus.busy, 1'b1);
        feed("ovl", 7, 16'b1011011, 16'b0001001);

        // Non-overlapping: only bit 4 hits, bit 7 is still filling.
        do_load(4'b1011, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        feed("novl", 7, 16'b1011011, 16'b0001000);
        chk("novl_busy", bus.busy, 1'b1);

        // Masked 1001 (middle bits don't care), non-overlapping.
        do_load(4'b1001, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        feed("mask", 8, 16'b11111001, 16'b00010001);

        // load together with a valid bit: bit dropped, window restarted.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        feed("ldpre", 2, 16'b10, 16'b00);
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("ld_bit_match", bus.match, 1'b0);
        feed("ldpost", 6, 16'b011011, 16'b000001);

        // en low for three cycles between bits 2 and 3, bit_vld toggling.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        feed("en", 2, 16'b10, 16'b00);
        step(1'b0, 1'b1, 1'b0);
        chk("en_off1_busy", bus.busy, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("en_off2_match", bus.match, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("en_off3_busy", bus.busy, 1'b0);
        feed("en_resume", 2, 16'b11, 16'b01);
        chk("en_resume_busy", bus.busy, 1'b1);

        // Reset mid-window: progress lost, the bit that would complete 1011
        // no longer hits.
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        feed("rstpre", 3, 16'b101, 16'b000);
        rst = 1'b1;
        #1;
        chk("rst_mid_match", bus.match, 1'b0);
        chk("rst_mid_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        feed("rstpost", 1, 16'b1, 16'b0);
        chk("rstpost_busy", bus.busy, 1'b1);

        // All-zero mask: every bit once full is a hit; counter saturates at 3.
        do_load(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        feed("m0fill", 3, 16'b101, 16'b000);
`ifdef MATCH_CNT_EN
        chk_cnt("m0fill_cnt", bus.match_cnt, 2'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, i[0]);
            chk($sformatf("m0_hit%0d", i + 1), bus.match, 1'b1);
`ifdef MATCH_CNT_EN
            chk_cnt($sformatf("m0_cnt%0d", i + 1), bus.match_cnt,
                    (i >= 2) ? 2'd3 : CNT_W'(i + 1));
`endif
        end
        do_load(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("m0_reload_match", bus.match, 1'b0);
`ifdef MATCH_CNT_EN
        chk_cnt("m0_reload_cnt", bus.match_cnt, 2'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
